traffic_spawner: RTL and testbench

- Upstream controller for the array of per-car instances. Drives SpawnEnable, SpawnX, SpawnY, Speed, Type and FaceLeft for every car slot.
- Slots are organised as NUM_LANES lanes × SLOTS_PER_LANE slots.
- Once per game round it picks per-lane speed and direction, then releases cars into each lane one at a time on LFSR-randomised gaps.
- Runs on the frame clock, one update per video frame.

---
 rtl/traffic_spawner.sv | 177 +++++++++++++++++
 tb/tb_traffic_spawner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_spawner.sv
// Per-round traffic controller: seeds lane speed/direction, then releases cars per lane on LFSR-randomised gaps.
// Optional build macro TRAFFIC_RANDOM_DIR_EN draws each lane direction from the LFSR instead of lane parity.
module traffic_spawner #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned SLOTS_PER_LANE = 3,
    parameter logic [9:0]  LANE_Y0        = 10'd120,
    parameter logic [9:0]  LANE_PITCH     = 10'd32,
    parameter int unsigned LANE_STAGGER   = 4,
    parameter int unsigned GAP_MIN        = 40,
    parameter logic [9:0]  SPAWN_X_LEFT   = 10'd740,
    parameter logic [9:0]  SPAWN_X_RIGHT  = 10'd51
) (
    input  logic                                    i_frame_clk,
    input  logic                                    i_reset,
    input  logic                                    i_game_active,
    input  logic [1:0]                              i_level,
    output logic [NUM_LANES*SLOTS_PER_LANE-1:0]     o_spawn_enable,
    output logic [NUM_LANES*SLOTS_PER_LANE-1:0]     o_face_left,
    output logic [2*NUM_LANES*SLOTS_PER_LANE-1:0]   o_type,
    output logic [3*NUM_LANES*SLOTS_PER_LANE-1:0]   o_speed,
    output logic [10*NUM_LANES*SLOTS_PER_LANE-1:0]  o_spawn_x,
    output logic [10*NUM_LANES*SLOTS_PER_LANE-1:0]  o_spawn_y,
    output logic                                    o_running
);
    localparam int unsigned N  = NUM_LANES * SLOTS_PER_LANE;
    localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CW = $clog2(SLOTS_PER_LANE + 1);
    localparam int unsigned TW = 10;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_CLEAR} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [15:0]     w_lfsr_nxt;
    logic [LW-1:0]   r_lane_idx;
    logic [CW-1:0]   r_count [NUM_LANES];
    logic [TW-1:0]   r_timer [NUM_LANES];
    logic [N-1:0]    r_spawn_enable;
    logic [N-1:0]    r_face_left;
    logic [2*N-1:0]  r_type;
    logic [3*N-1:0]  r_speed;
    logic [10*N-1:0] r_spawn_x;
    logic [10*N-1:0] r_spawn_y;
    logic            r_running;

    logic [NUM_LANES-1:0] w_lane_dir;
    logic [2:0]           w_lane_speed [NUM_LANES];
    logic [1:0]           w_lane_type  [NUM_LANES];
    logic [TW-1:0]        w_reload     [NUM_LANES];

    // r(j): LFSR bit j mod 16, taken before this frame's advance
    function automatic logic rbit(input logic [15:0] v, input int j);
        return v[4'(j)];
    endfunction

    function automatic logic [2:0] lane_speed(input logic [15:0] v, input int l, input logic [1:0] lvl);
        logic [2:0] base;
        logic [3:0] sum;
        base = {rbit(v, 3*l + 2), rbit(v, 3*l + 1), rbit(v, 3*l)};
        if (base == 3'd0) base = 3'd1;
        sum = 4'(base) + 4'(lvl);
        return (sum > 4'd7) ? 3'd7 : sum[2:0];
    endfunction

    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

    // Per-lane random draws for seeding and spawning
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
`ifdef TRAFFIC_RANDOM_DIR_EN
            w_lane_dir[l] = rbit(r_lfsr, 15 - l);
`else
            w_lane_dir[l] = ((l % 2) == 0);
`endif
            w_lane_speed[l] = lane_speed(r_lfsr, l, i_level);
            w_lane_type[l]  = {rbit(r_lfsr, 2*l + 1), rbit(r_lfsr, 2*l)};
            w_reload[l]     = TW'(GAP_MIN) +
                              TW'({rbit(r_lfsr, l + 6), rbit(r_lfsr, l + 5), rbit(r_lfsr, l + 4), 3'b000});
        end
    end

    always_ff @(posedge i_frame_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_game_active) w_state_nxt = S_SEED;
            S_SEED: begin
                if (!i_game_active)                         w_state_nxt = S_CLEAR;
                else if (r_lane_idx == LW'(NUM_LANES - 1)) w_state_nxt = S_RUN;
            end
            S_RUN:   if (!i_game_active) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_frame_clk) begin
        if (i_reset) begin
            r_lfsr         <= LFSR_SEED;
            r_lane_idx     <= '0;
            r_running      <= 1'b0;
            r_spawn_enable <= '0;
            r_face_left    <= '0;
            r_type         <= '0;
            r_speed        <= '0;
            r_spawn_x      <= '0;
            r_spawn_y      <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                r_count[l] <= '0;
                r_timer[l] <= '0;
            end
        end else begin
            r_lfsr    <= w_lfsr_nxt;
            r_running <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
            case (r_state)
                S_IDLE: r_lane_idx <= '0;
                S_SEED: begin
                    r_lane_idx <= r_lane_idx + 1'b1;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (r_lane_idx == LW'(l)) begin
                            r_count[l] <= '0;
                            r_timer[l] <= TW'(l * LANE_STAGGER);
                            for (int k = 0; k < SLOTS_PER_LANE; k++) begin
                                r_face_left[l*SLOTS_PER_LANE + k]          <= w_lane_dir[l];
                                r_speed[3*(l*SLOTS_PER_LANE + k) +: 3]     <= w_lane_speed[l];
                                r_spawn_x[10*(l*SLOTS_PER_LANE + k) +: 10] <=
                                    w_lane_dir[l] ? SPAWN_X_LEFT : SPAWN_X_RIGHT;
                                r_spawn_y[10*(l*SLOTS_PER_LANE + k) +: 10] <= 10'(LANE_Y0 + l * LANE_PITCH);
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (w_state_nxt != S_RUN) begin
                        r_spawn_enable <= '0;
                    end else begin
                        // Lanes are independent; several may spawn in the same frame
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (r_count[l] < CW'(SLOTS_PER_LANE)) begin
                                if (r_timer[l] == '0) begin
                                    for (int k = 0; k < SLOTS_PER_LANE; k++) begin
                                        if (r_count[l] == CW'(k)) begin
                                            r_spawn_enable[l*SLOTS_PER_LANE + k]    <= 1'b1;
                                            r_type[2*(l*SLOTS_PER_LANE + k) +: 2] <= w_lane_type[l];
                                        end
                                    end
                                    r_count[l] <= r_count[l] + 1'b1;
                                    r_timer[l] <= w_reload[l];
                                end else begin
                                    r_timer[l] <= r_timer[l] - 1'b1;
                                end
                            end
                        end
                    end
                end
                S_CLEAR: r_spawn_enable <= '0;
                default: r_spawn_enable <= '0;
            endcase
        end
    end

    assign o_spawn_enable = r_spawn_enable;
    assign o_face_left    = r_face_left;
    assign o_type         = r_type;
    assign o_speed        = r_speed;
    assign o_spawn_x      = r_spawn_x;
    assign o_spawn_y      = r_spawn_y;
    assign o_running      = r_running;

endmodule

// File: tb/tb_traffic_spawner.sv
// Directed bench for traffic_spawner: reset, two rounds against an LFSR model, CLEAR/IDLE sequencing.
module tb_traffic_spawner;
    localparam int NL   = 4;
    localparam int SP   = 3;
    localparam int NS   = NL * SP;
    localparam int STAG = 4;
    localparam int GAPM = 40;

    logic            clk;
    logic            rst;
    logic            ga;
    logic [1:0]      lvl;
    logic [NS-1:0]   en;
    logic [NS-1:0]   face;
    logic [2*NS-1:0] typ;
    logic [3*NS-1:0] spd;
    logic [10*NS-1:0] sx;
    logic [10*NS-1:0] sy;
    logic            running;

    int          n_checks;
    int          n_errors;
    int          ecount;
    int          f1;
    int          f2;
    logic [15:0] pre [0:2047];
    int          sp_edge [NS];

    traffic_spawner dut (
        .i_frame_clk    (clk),
        .i_reset        (rst),
        .i_game_active  (ga),
        .i_level        (lvl),
        .o_spawn_enable (en),
        .o_face_left    (face),
        .o_type         (typ),
        .o_speed        (spd),
        .o_spawn_x      (sx),
        .o_spawn_y      (sy),
        .o_running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (frame %0d)", tag, got, exp, ecount);
        end
    endtask

    // One frame; ecount numbers the edges seen with reset low
    task automatic tick();
        @(posedge clk);
        if (!rst) ecount++;
        #1;
    endtask

    function automatic int rb(input logic [15:0] v, input int j);
        logic [15:0] t;
        t = v >> (j % 16);
        return int'(t[0]);
    endfunction

    function automatic int exp_speed(input logic [15:0] v, input int l, input int lv);
        int b;
        b = 4*rb(v, 3*l + 2) + 2*rb(v, 3*l + 1) + rb(v, 3*l);
        if (b == 0) b = 1;
        b = b + lv;
        if (b > 7) b = 7;
        return b;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"},  en, 0);
        chk({tag, "_run"}, running, 0);
        chk({tag, "_spd"}, |spd, 0);
        chk({tag, "_sx"},  |sx, 0);
        chk({tag, "_sy"},  |sy, 0);
        chk({tag, "_fl"},  |face, 0);
        chk({tag, "_ty"},  |typ, 0);
    endtask

    // GameActive must be sampled high at edge f with the DUT in IDLE; ecount == f-1 on entry
    task automatic do_round(input int f, input logic [1:0] l0, input int nfr);
        int          t;
        int          s;
        int          e_spd [NL];
        logic        e_dir [NL];
        logic [15:0] v;
        logic [NS-1:0] exp_en;
        lvl = l0;
        for (int l = 0; l < NL; l++) begin
            v = pre[f + 1 + l];
            e_spd[l] = exp_speed(v, l, int'(l0));
`ifdef TRAFFIC_RANDOM_DIR_EN
            e_dir[l] = (rb(v, 15 - l) != 0);
`else
            e_dir[l] = ((l % 2) == 0);
`endif
            t = f + 5 + l * STAG;
            for (int k = 0; k < SP; k++) begin
                sp_edge[l*SP + k] = t;
                t = t + GAPM + 8 * (4*rb(pre[t], l + 6) + 2*rb(pre[t], l + 5) + rb(pre[t], l + 4)) + 1;
            end
        end
        while (ecount < f + nfr) begin
            tick();
            if (ecount == f + 50) lvl = ~l0;
            for (int q = 0; q < NS; q++) exp_en[q] = (ecount >= sp_edge[q]);
            chk("en_vec", en, exp_en);
            chk("running", running, ecount >= f + 5);
            if (ecount == f + 5) chk("en0_first", en[0], 1);
            if (ecount == f + 8) chk("en3_early", en[3], 0);
            if (ecount == f + 9) chk("en3_first", en[3], 1);
            if (ecount == f + 4 || ecount == f + nfr) begin
                for (int l = 0; l < NL; l++) begin
                    for (int k = 0; k < SP; k++) begin
                        s = l*SP + k;
                        chk($sformatf("spd%0d", s), spd[3*s +: 3], e_spd[l]);
                        chk($sformatf("spd_rng%0d", s),
                            (int'(spd[3*s +: 3]) >= 1 + int'(l0)) && (spd[3*s +: 3] <= 3'd7), 1);
                        chk($sformatf("face%0d", s), face[s], e_dir[l]);
                        chk($sformatf("sx%0d", s), sx[10*s +: 10], e_dir[l] ? 740 : 51);
                        chk($sformatf("sy%0d", s), sy[10*s +: 10], 120 + 32*l);
                    end
                end
            end
            if (ecount == f + nfr) begin
                for (int l = 0; l < NL; l++) begin
                    for (int k = 0; k < SP; k++) begin
                        s = l*SP + k;
                        if (ecount >= sp_edge[s])
                            chk($sformatf("type%0d", s), typ[2*s +: 2],
                                2*rb(pre[sp_edge[s]], 2*l + 1) + rb(pre[sp_edge[s]], 2*l));
                    end
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        ga       = 1'b0;
        lvl      = 2'd0;
        ecount   = 0;
        n_checks = 0;
        n_errors = 0;
        pre[0]   = 16'h0000;
        pre[1]   = 16'hACE1;
        for (int e = 1; e < 2047; e++)
            pre[e + 1] = {1'b0, pre[e][15:1]} ^ (pre[e][0] ? 16'hB400 : 16'h0000);

        tick();
        tick();
        check_all_zero("rst");
        rst = 1'b0;
        repeat (3) tick();
        check_all_zero("idle");

        // Round 1: full release at Level 3, Level changed mid-run
        ga = 1'b1;
        f1 = ecount + 1;
        do_round(f1, 2'd3, 260);

        // Drop, then re-raise during CLEAR: must still pass through IDLE
        ga = 1'b0;
        tick();
        chk("clr_en", en, 0);
        chk("clr_run", running, 0);
        ga = 1'b1;
        tick();
        chk("idle_en", en, 0);
        chk("idle_run", running, 0);

        // Round 2: Level 0, dropped mid-run
        f2 = ecount + 1;
        do_round(f2, 2'd0, 100);
        ga = 1'b0;
        tick();
        chk("drop_en", en, 0);
        chk("drop_run", running, 0);
        tick();
        chk("drop_idle_en", en, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
